// File: rtl/fsm_stream_arbiter_if.sv
// fsm_stream_arbiter_if
//   Request/response bundle between NREQ requesters and fsm_stream_arbiter.
//   Ports (signals):
//     req_valid  [NREQ]    per-requester request pending
//     req_data   [NREQ*W]  request words, requester i on [i*W +: W]
//     req_ready  [NREQ]    one-hot accept pulse, word latched in this cycle
//     resp_valid           result available
//     resp_ready           consumer accepts result
//     resp_id    [IDW]     requester the result belongs to
//     resp_data  [W]       detector output bits, bit k for input bit k
//   Modports: master = requester side, slave = arbiter side.
interface fsm_stream_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/fsm_stream_arbiter.sv
// fsm_stream_arbiter
//   Shares one serial Mealy sequence detector among NREQ requesters. A granted
//   word is shifted into the detector LSB first after a one-cycle detector
//   clear; the per-bit detector outputs are collected into a W-bit result that
//   is returned on a valid/ready response channel.
//
//   Build option: define FSMARB_ROUND_ROBIN_EN for round-robin arbitration
//   (priority pointer moves past the served requester on each response
//   handshake). Without it, the lowest valid index wins and no pointer exists.
//
//   Ports:
//     clock      system clock, posedge
//     reset_b    asynchronous active-low reset
//     bus        fsm_stream_arbiter_if.slave (req_* / resp_* channels)
//     det_rst_b  registered active-low detector reset (low in CLEAR)
//     det_in     registered serial bit to the detector
//     det_out    detector Mealy output, combinational on det_in
//     busy       high whenever the FSM is not in IDLE
//
//   state | meaning
//   IDLE  | waiting for any req_valid; grants and latches the winner's word
//   CLEAR | detector held in reset for one cycle, bit counter cleared
//   SHIFT | one word bit per cycle into the detector, output bit captured
//   DONE  | result presented on resp_*, held until resp_ready
module fsm_stream_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                 clock,
  input  logic                 reset_b,
  fsm_stream_arbiter_if.slave  bus,
  output logic                 det_rst_b,
  output logic                 det_in,
  input  logic                 det_out,
  output logic                 busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_n;
  logic [W-1:0]   sh_q, sh_n;
  logic [CW-1:0]  cnt_q, cnt_n;
  logic [IDW-1:0] id_q, id_n;
  logic [W-1:0]   data_q, data_n;
  logic           det_rst_b_n;
  logic           det_in_n;

  logic           any_valid;
  logic [IDW-1:0] winner;

`ifdef FSMARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      ptr_q <= '0;
    end else if (state_q == DONE && bus.resp_ready) begin
      ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  // Walk from the farthest offset back to the pointer so the last hit is the
  // first valid index at or after the pointer (mod NREQ).
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        winner    = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end
`else
  // Fixed priority: descending scan leaves the lowest valid index.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        winner    = IDW'(i);
        any_valid = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      data_q    <= '0;
      det_rst_b <= 1'b0;
      det_in    <= 1'b0;
    end else begin
      state_q   <= state_n;
      sh_q      <= sh_n;
      cnt_q     <= cnt_n;
      id_q      <= id_n;
      data_q    <= data_n;
      det_rst_b <= det_rst_b_n;
      det_in    <= det_in_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    sh_n          = sh_q;
    cnt_n         = cnt_q;
    id_n          = id_q;
    data_n        = data_q;
    bus.req_ready = '0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          // Accept pulse is combinational; gating with reset_b keeps it low
          // while the block is held in reset.
          bus.req_ready[winner] = reset_b;
          sh_n                  = bus.req_data[winner*W +: W];
          id_n                  = winner;
          state_n               = CLEAR;
        end
      end
      CLEAR: begin
        cnt_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        for (int k = 0; k < W; k++) begin
          if (cnt_q == CW'(k)) data_n[k] = det_out;
        end
        sh_n  = sh_q >> 1;
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_n = DONE;
      end
      DONE: begin
        if (bus.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // det_* are registered, so they are derived from next-cycle state: the
    // detector sees sh[0] during every SHIFT cycle and a reset during CLEAR.
    det_rst_b_n = (state_n != CLEAR);
    det_in_n    = (state_n == SHIFT) ? sh_n[0] : 1'b0;
  end

  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// tb_fsm_stream_arbiter
//   Self-checking bench for fsm_stream_arbiter with the team serial detector
//   attached to det_*. Table vectors, hand sequences (arbitration, backpressure,
//   mid-word reset) and a randomized phase checked against a table-driven
//   detector model and a modular-search arbitration model.
module tb_fsm_stream_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int TO   = W + 20;

  logic clock;
  logic reset_b;
  logic det_rst_b, det_in, det_out, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ptr_m  = 0;

  fsm_stream_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  fsm_stream_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .bus       (bus),
    .det_rst_b (det_rst_b),
    .det_in    (det_in),
    .det_out   (det_out),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Team serial detector: 0 = S0, 1 = S1, 2 = S2.
  logic [1:0] ds;
  always_comb begin
    case (ds)
      2'd0:    det_out = ~det_in;
      2'd2:    det_out = det_in;
      default: det_out = 1'b1;
    endcase
  end
  always_ff @(posedge clock or negedge det_rst_b) begin
    if (!det_rst_b) ds <= 2'd0;
    else begin
      case (ds)
        2'd0:    if (det_in) ds <= 2'd2;
        2'd2:    if (!det_in) ds <= 2'd1;
        default: ds <= 2'd0;
      endcase
    end
  end

  // Reference detector as transition/output tables indexed [state][bit].
  function automatic logic [W-1:0] ref_detect(input logic [W-1:0] word);
    int out_t [0:2][0:1];
    int nxt_t [0:2][0:1];
    int s;
    logic [W-1:0] r;
    out_t = '{'{1, 0}, '{1, 1}, '{0, 1}};
    nxt_t = '{'{0, 2}, '{0, 0}, '{1, 2}};
    s = 0;
    r = '0;
    for (int k = 0; k < W; k++) begin
      r[k] = out_t[s][int'(word[k])][0];
      s    = nxt_t[s][int'(word[k])];
    end
    return r;
  endfunction

  function automatic int ref_winner(input logic [NREQ-1:0] v, input int ptr);
`ifdef FSMARB_ROUND_ROBIN_EN
    for (int i = 0; i < NREQ; i++) if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
`else
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Call at a negedge after driving inputs; returns at negedge+1 of grant cycle.
  task automatic wait_grant(output int id, output bit ok);
    ok = 1'b0;
    id = -1;
    for (int n = 0; n < TO; n++) begin
      #1;
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) id = i;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < TO; n++) begin
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // One complete word; hold > 0 keeps resp_ready low that many cycles in DONE
  // while the same requests are re-asserted.
  task automatic do_word(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] data,
                         input int hold, output int got_id, output logic [W-1:0] got_data);
    int exp_id, gid, t0, bad, nid;
    logic [W-1:0] exp_data;
    bit ok;
    exp_id   = ref_winner(mask, ptr_m);
    exp_data = ref_detect(data[exp_id*W +: W]);
    got_id   = -1;
    got_data = '0;
    @(negedge clock);
    bus.req_valid  = mask;
    bus.req_data   = data;
    bus.resp_ready = (hold == 0);
    wait_grant(gid, ok);
    check("grant_seen", 32'(ok), 32'd1);
    if (!ok) begin
      bus.req_valid = '0;
      return;
    end
    t0 = cyc;
    check("grant_id", gid, exp_id);
    check("req_ready_onehot", 32'(bus.req_ready), 32'(1 << exp_id));
    @(negedge clock);
    bus.req_valid = '0;
    bus.req_data  = ~data;
    check("clear_det_rst_b", 32'(det_rst_b), 32'd0);
    check("clear_busy", 32'(busy), 32'd1);
    wait_resp(ok);
    check("resp_seen", 32'(ok), 32'd1);
    check("latency", cyc - t0, W + 2);
    check("resp_id", 32'(bus.resp_id), exp_id);
    check("resp_data", 32'(bus.resp_data), 32'(exp_data));
    got_id   = int'(bus.resp_id);
    got_data = bus.resp_data;
    if (hold > 0) begin
      bus.req_valid = mask;
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        if (!(bus.resp_valid && bus.resp_id == IDW'(exp_id) && bus.resp_data == exp_data &&
              bus.req_ready == '0 && busy)) bad++;
      end
      check("backpressure_stable", bad, 0);
      bus.resp_ready = 1'b1;
    end
`ifdef FSMARB_ROUND_ROBIN_EN
    ptr_m = (exp_id + 1) % NREQ;
`endif
    @(negedge clock);
    check("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    if (hold > 0) begin
      nid = ref_winner(mask, ptr_m);
      #1;
      check("regrant_next_cycle", 32'(bus.req_ready), 32'(1 << nid));
      bus.req_valid = '0;
      #1;
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]   mask;
    logic [NREQ*W-1:0] data;
    int                exp_id;
    logic [W-1:0]      exp_data;
  } vec_t;

  vec_t vecs [6];
  int   arb_exp [4];

  initial begin
    int gid, prev, rv_seen, bz_seen;
    logic [W-1:0] gd;
    bit ok;

    vecs[0] = '{mask: 4'b0001, data: 32'h0000_0000, exp_id: 0, exp_data: 8'hFF};
    vecs[1] = '{mask: 4'b0100, data: 32'h00FF_0000, exp_id: 2, exp_data: 8'hFE};
    vecs[2] = '{mask: 4'b0010, data: 32'hEE33_01AA, exp_id: 1, exp_data: 8'hFC};
    vecs[3] = '{mask: 4'b0001, data: 32'h0000_00FF, exp_id: 0, exp_data: 8'hFE};
    vecs[4] = '{mask: 4'b0001, data: 32'h0000_0000, exp_id: 0, exp_data: 8'hFF};
    vecs[5] = '{mask: 4'b1000, data: 32'hA500_0000, exp_id: 3, exp_data: 8'h9C};
`ifdef FSMARB_ROUND_ROBIN_EN
    arb_exp = '{0, 1, 2, 3};
`else
    arb_exp = '{0, 0, 0, 0};
`endif

    // Reset values, with requests pending to show the accept pulse is held off.
    reset_b        = 1'b0;
    bus.req_valid  = 4'b0011;
    bus.req_data   = 32'h1234_5678;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_det_rst_b", 32'(det_rst_b), 32'd0);
    check("rst_det_in", 32'(det_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    bus.req_valid = '0;
    reset_b       = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("idle_req_ready", 32'(bus.req_ready), 32'd0);

    // All requesters continuously valid: grant order and minimum spacing.
    bus.req_valid  = '1;
    bus.req_data   = 32'h5A3C_F001;
    bus.resp_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(gid, ok);
      check("arb_grant_seen", 32'(ok), 32'd1);
      check("arb_order", gid, arb_exp[k]);
      if (k > 0) check("arb_spacing", cyc - prev, W + 3);
      prev = cyc;
      wait_resp(ok);
      check("arb_resp_seen", 32'(ok), 32'd1);
      check("arb_resp_data", 32'(bus.resp_data), 32'(ref_detect(bus.req_data[arb_exp[k]*W +: W])));
`ifdef FSMARB_ROUND_ROBIN_EN
      ptr_m = (arb_exp[k] + 1) % NREQ;
`endif
      if (k == 3) bus.req_valid = '0;
      @(negedge clock);
    end

    // Table vectors (includes back-to-back FF then 00).
    for (int i = 0; i < 6; i++) begin
      do_word(vecs[i].mask, vecs[i].data, 0, gid, gd);
      check("vec_id", gid, vecs[i].exp_id);
      check("vec_data", 32'(gd), 32'(vecs[i].exp_data));
    end

    // Backpressure: 20 cycles with resp_ready low.
    do_word(4'b1000, 32'hA500_0000, 20, gid, gd);
    check("bp_data", 32'(gd), 32'h9C);

    // Reset while bit 3 is being presented.
    @(negedge clock);
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h005A_0000;
    wait_grant(gid, ok);
    check("mid_grant_seen", 32'(ok), 32'd1);
    @(negedge clock);
    bus.req_valid = '0;
    repeat (4) @(negedge clock);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_det_in_bit3", 32'(det_in), 32'd1);
    check("mid_det_rst_b", 32'(det_rst_b), 32'd1);
    bus.req_valid = 4'b0100;
    reset_b = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_det_rst_b", 32'(det_rst_b), 32'd0);
    check("mid_rst_det_in", 32'(det_in), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_resp_data", 32'(bus.resp_data), 32'd0);
    @(negedge clock);
    bus.req_valid = '0;
    reset_b = 1'b1;
    ptr_m = 0;
    rv_seen = 0;
    bz_seen = 0;
    for (int n = 0; n < W + 5; n++) begin
      @(negedge clock);
      if (bus.resp_valid) rv_seen++;
      if (busy) bz_seen++;
    end
    check("mid_no_resp", rv_seen, 0);
    check("mid_stays_idle", bz_seen, 0);
    do_word(4'b0100, 32'h005A_0000, 0, gid, gd);
    check("mid_reissue_data", 32'(gd), 32'hC9);

    // Randomized requests, data and backpressure against the models.
    for (int r = 0; r < 40; r++) begin
      do_word(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom, $urandom_range(0, 3), gid, gd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
